mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the memory byte width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 12, giving the byte-address width in bits.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port i_req_valid, input, 1 bit: a request is presented.
REQ-006 The block SHALL have port o_req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have port i_req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port i_req_size, input, 2 bits: 00 = byte, 01 = half, 11 = word, 10 = illegal.
REQ-009 The block SHALL have port i_req_unsigned, input, 1 bit: 1 = zero-extend loads, 0 = sign-extend loads.
REQ-010 The block SHALL have port i_req_addr, input, ADDR_WIDTH bits: byte address.
REQ-011 The block SHALL have port i_req_wdata, input, 4*DATA_WIDTH bits: store data, right-justified.
REQ-012 The block SHALL have port o_rsp_valid, output, 1 bit: one-cycle response pulse.
REQ-013 The block SHALL have port o_rsp_err, output, 1 bit: response is an error, valid with o_rsp_valid.
REQ-014 The block SHALL have port o_rsp_rdata, output, 4*DATA_WIDTH bits: extended load data; 0 for stores and errors.
REQ-015 The block SHALL have port o_mem_we, output, 1 bit: RAM write enable.
REQ-016 The block SHALL have port o_mem_addr, output, ADDR_WIDTH bits: RAM byte address, always word-aligned (bits [1:0] = 00).
REQ-017 The block SHALL have port o_mem_wdata, output, 4*DATA_WIDTH bits: RAM write word; byte at addr in [7:0], addr+3 in [31:24].
REQ-018 The block SHALL have port i_mem_rdata, input, 4*DATA_WIDTH bits: asynchronous RAM read word, same byte order as o_mem_wdata.

Function
REQ-019 The block SHALL implement states IDLE, LOAD, RMW_RD, WRITE and RESP.
REQ-020 The block SHALL drive o_req_ready=1 only in IDLE, and SHALL latch all request fields on the cycle where valid and ready are both 1 (cycle 0).
REQ-021 From IDLE, an accepted request SHALL go to: RESP with error when size=10, half with addr[0]=1 or word with addr[1:0]≠00; LOAD when we=0; WRITE when we=1 and size=11; otherwise RMW_RD.
REQ-022 o_mem_addr SHALL equal {latched addr[ADDR_WIDTH-1:2], 2'b00} in LOAD, RMW_RD and WRITE, and 0 in IDLE and RESP.
REQ-023 In LOAD the block SHALL select the lane by addr[1:0] (byte) or addr[1] (half), extend it per the unsigned flag, and register the result into o_rsp_rdata; the next state SHALL be RESP.
REQ-024 In RMW_RD the block SHALL capture i_mem_rdata, replace only the addressed byte or half with the low bits of the write data, hold the merged word, and go to WRITE.
REQ-025 In WRITE the block SHALL drive o_mem_we=1 with o_mem_wdata equal to the merged word, or to the full write data for word stores, and go to RESP; o_mem_we SHALL be 0 in every other state.
REQ-026 In RESP the block SHALL drive o_rsp_valid=1 for exactly one cycle and return to IDLE; o_rsp_err and o_rsp_rdata SHALL hold until the next response.
REQ-027 Latency from cycle 0 to o_rsp_valid SHALL be: error 1 cycle; load 2 cycles; word store 2 cycles; byte/half store 3 cycles.
REQ-028 An error response SHALL produce no RAM write and o_rsp_rdata=0.
REQ-029 The block SHALL ignore i_req_valid while not in IDLE; there is no response back-pressure.
REQ-030 Because aligned words never exceed address 2**ADDR_WIDTH-4, the block SHALL never address past the top of memory.

Reset
REQ-031 While i_rst_n=0 the block SHALL immediately force state=IDLE, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0 and o_req_ready=0.
REQ-032 A reset during LOAD, RMW_RD or WRITE SHALL abandon the access with no response; o_req_ready SHALL be 1 on the first clock after release.

Verification
REQ-033 Word store 0xDEADBEEF @0x010, then word load @0x010: o_mem_we high 1 cycle, store rsp at cycle 2, then rdata=0xDEADBEEF at cycle 2 with err=0.
REQ-034 Word 0x11223344 @0x010, then byte store 0xA5 @0x013 -> RAM word 0xA5223344; signed byte load @0x013 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
REQ-035 Word 0x80017FFF @0x020: signed half load @0x022 -> 0xFFFF8001; signed half load @0x020 -> 0x00007FFF; half store 0xBEEF @0x022 -> word 0xBEEF7FFF at cycle 3.
REQ-036 Word load @0x021, half store @0x023 and size=10 @0x000 -> each err=1 at cycle 1, o_mem_we never asserted, memory unchanged.
REQ-037 Reset pulsed during RMW_RD of a byte store @0x010 -> o_mem_we stays 0, no rsp, word unchanged, ready=1 after release.
REQ-038 i_req_valid held high over 3 back-to-back byte stores -> ready low in all non-IDLE cycles, each request accepted once, responses 4 cycles apart.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Byte/half/word load-store controller in front of a word-wide RAM with
// asynchronous read; sub-word stores are done as read-modify-write.
module mem_access_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [1:0]              i_req_size,
    input  logic                    i_req_unsigned,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [4*DATA_WIDTH-1:0] i_req_wdata,
    output logic                    o_rsp_valid,
    output logic                    o_rsp_err,
    output logic [4*DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                    o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [4*DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [4*DATA_WIDTH-1:0] i_mem_rdata
);
    localparam int DW = DATA_WIDTH;
    localparam int WW = 4 * DATA_WIDTH;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

    state_t                state_reg, state_next;
    logic [1:0]            size_reg;
    logic                  unsigned_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [WW-1:0]         word_reg;
    logic                  rsp_err_reg;
    logic [WW-1:0]         rsp_rdata_reg;

    logic                  accept;
    logic                  req_bad;
    logic [DW-1:0]         rd_lane [4];
    logic [DW-1:0]         byte_lane;
    logic [2*DW-1:0]       half_lane;
    logic [WW-1:0]         load_ext;
    logic [WW-1:0]         merged;

    assign accept  = i_req_valid && o_req_ready;
    assign req_bad = (i_req_size == 2'b10)
                  || (i_req_size == SIZE_HALF && i_req_addr[0])
                  || (i_req_size == SIZE_WORD && i_req_addr[1:0] != 2'b00);

    // Split the RAM word into lanes and build the RMW word lane by lane:
    // an addressed lane takes store data, all others keep the RAM contents.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic hit_byte;
            logic hit_half;
            assign rd_lane[gi] = i_mem_rdata[gi*DW +: DW];
            assign hit_byte    = (size_reg == SIZE_BYTE) && (addr_reg[1:0] == 2'(gi));
            assign hit_half    = (size_reg == SIZE_HALF) && (addr_reg[1] == 1'(gi / 2));
            assign merged[gi*DW +: DW] = hit_byte ? word_reg[DW-1:0] :
                                         hit_half ? word_reg[(gi % 2)*DW +: DW] :
                                                    rd_lane[gi];
        end
    endgenerate

    always_comb begin
        byte_lane = rd_lane[addr_reg[1:0]];
        half_lane = {rd_lane[{addr_reg[1], 1'b1}], rd_lane[{addr_reg[1], 1'b0}]};
        load_ext  = i_mem_rdata;
        if (size_reg == SIZE_BYTE) begin
            load_ext = unsigned_reg ? {{(3*DW){1'b0}}, byte_lane}
                                    : {{(3*DW){byte_lane[DW-1]}}, byte_lane};
        end else if (size_reg == SIZE_HALF) begin
            load_ext = unsigned_reg ? {{(2*DW){1'b0}}, half_lane}
                                    : {{(2*DW){half_lane[2*DW-1]}}, half_lane};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (req_bad)                      state_next = RESP;
                    else if (!i_req_we)               state_next = LOAD;
                    else if (i_req_size == SIZE_WORD) state_next = WRITE;
                    else                              state_next = RMW_RD;
                end
            end
            LOAD:    state_next = RESP;
            RMW_RD:  state_next = WRITE;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Response fields only change on the edge that enters RESP, so they hold
    // between responses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            size_reg      <= '0;
            unsigned_reg  <= 1'b0;
            addr_reg      <= '0;
            word_reg      <= '0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            if (accept) begin
                size_reg     <= i_req_size;
                unsigned_reg <= i_req_unsigned;
                addr_reg     <= i_req_addr;
                word_reg     <= i_req_wdata;
                if (req_bad) begin
                    rsp_err_reg   <= 1'b1;
                    rsp_rdata_reg <= '0;
                end
            end
            if (state_reg == LOAD) begin
                rsp_err_reg   <= 1'b0;
                rsp_rdata_reg <= load_ext;
            end
            if (state_reg == RMW_RD) begin
                word_reg <= merged;
            end
            if (state_reg == WRITE) begin
                rsp_err_reg   <= 1'b0;
                rsp_rdata_reg <= '0;
            end
        end
    end

    always_comb begin
        o_req_ready = i_rst_n && (state_reg == IDLE);
        o_mem_we    = (state_reg == WRITE);
        o_mem_addr  = '0;
        if (state_reg == LOAD || state_reg == RMW_RD || state_reg == WRITE) begin
            o_mem_addr = {addr_reg[ADDR_WIDTH-1:2], 2'b00};
        end
        o_mem_wdata = (state_reg == WRITE) ? word_reg : '0;
        o_rsp_valid = (state_reg == RESP);
        o_rsp_err   = rsp_err_reg;
        o_rsp_rdata = rsp_rdata_reg;
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a word RAM (async read) attached.
module tb_mem_access_ctrl;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];

    int total = 0;
    int bad   = 0;

    mem_access_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_we(req_we), .i_req_size(req_size), .i_req_unsigned(req_unsigned),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .o_rsp_err(rsp_err), .o_rsp_rdata(rsp_rdata),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;

    // One request from an IDLE negedge; returns at the negedge showing the response.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [11:0] addr, input logic [31:0] wdata,
                          output int lat, output logic err, output logic [31:0] rdata,
                          output int wr_cnt, output logic [11:0] wr_addr);
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = -1; err = 1'bx; rdata = 'x; wr_cnt = 0; wr_addr = 'x;
        for (int c = 1; c <= 8; c++) begin
            if (mem_we) begin wr_cnt++; wr_addr = mem_addr; end
            if (rsp_valid) begin
                lat = c; err = rsp_err; rdata = rsp_rdata;
                break;
            end
            @(negedge clk);
        end
        $display("req we=%0b size=%0b uns=%0b addr=%h wdata=%h -> lat=%0d err=%0b rdata=%h writes=%0d",
                 we, size, uns, addr, wdata, lat, err, rdata, wr_cnt);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_size = 2'b11;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_err, mem_we} !== 4'b0000 || rsp_rdata !== 32'h0
            || mem_addr !== 12'h0 || mem_wdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b rsp=%b err=%b we=%b rdata=%h addr=%h wdata=%h want all 0",
                     req_ready, rsp_valid, rsp_err, mem_we, rsp_rdata, mem_addr, mem_wdata);
        end
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready_after: got %b want 1", req_ready);
        end
    endtask

    task automatic test_word_store_load();
        int lat, wc; logic err; logic [31:0] rd; logic [11:0] wa;
        do_req(1'b1, 2'b11, 1'b0, 12'h010, 32'hDEADBEEF, lat, err, rd, wc, wa);
        total++;
        if (lat !== 2 || err !== 1'b0 || rd !== 32'h0 || wc !== 1) begin
            bad++; $display("FAIL word_store: lat=%0d err=%b rdata=%h writes=%0d want 2/0/0/1", lat, err, rd, wc);
        end
        total++;
        if (wa !== 12'h010) begin bad++; $display("FAIL word_store_addr: got %h want 010", wa); end
        do_req(1'b0, 2'b11, 1'b0, 12'h010, 32'h0, lat, err, rd, wc, wa);
        total++;
        if (lat !== 2 || err !== 1'b0 || rd !== 32'hDEADBEEF || wc !== 0) begin
            bad++; $display("FAIL word_load: lat=%0d err=%b rdata=%h writes=%0d want 2/0/DEADBEEF/0", lat, err, rd, wc);
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rsp_hold: valid=%b rdata=%h want 0/DEADBEEF", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_byte_rmw();
        int lat, wc; logic err; logic [31:0] rd; logic [11:0] wa;
        do_req(1'b1, 2'b11, 1'b0, 12'h010, 32'h11223344, lat, err, rd, wc, wa);
        do_req(1'b1, 2'b00, 1'b0, 12'h013, 32'h000000A5, lat, err, rd, wc, wa);
        total++;
        if (lat !== 3 || err !== 1'b0 || wc !== 1 || wa !== 12'h010) begin
            bad++; $display("FAIL byte_store: lat=%0d err=%b writes=%0d addr=%h want 3/0/1/010", lat, err, wc, wa);
        end
        total++;
        if (mem[4] !== 32'hA5223344) begin bad++; $display("FAIL byte_store_mem: got %h want A5223344", mem[4]); end
        do_req(1'b0, 2'b00, 1'b0, 12'h013, 32'h0, lat, err, rd, wc, wa);
        total++;
        if (lat !== 2 || rd !== 32'hFFFFFFA5) begin
            bad++; $display("FAIL byte_load_signed: lat=%0d rdata=%h want 2/FFFFFFA5", lat, rd);
        end
        do_req(1'b0, 2'b00, 1'b1, 12'h013, 32'h0, lat, err, rd, wc, wa);
        total++;
        if (rd !== 32'h000000A5) begin bad++; $display("FAIL byte_load_unsigned: got %h want 000000A5", rd); end
        do_req(1'b0, 2'b00, 1'b0, 12'h011, 32'h0, lat, err, rd, wc, wa);
        total++;
        if (rd !== 32'h00000033) begin bad++; $display("FAIL byte_load_lane1: got %h want 00000033", rd); end
    endtask

    task automatic test_half();
        int lat, wc; logic err; logic [31:0] rd; logic [11:0] wa;
        do_req(1'b1, 2'b11, 1'b0, 12'h020, 32'h80017FFF, lat, err, rd, wc, wa);
        do_req(1'b0, 2'b01, 1'b0, 12'h022, 32'h0, lat, err, rd, wc, wa);
        total++;
        if (rd !== 32'hFFFF8001) begin bad++; $display("FAIL half_load_hi: got %h want FFFF8001", rd); end
        do_req(1'b0, 2'b01, 1'b0, 12'h020, 32'h0, lat, err, rd, wc, wa);
        total++;
        if (rd !== 32'h00007FFF) begin bad++; $display("FAIL half_load_lo: got %h want 00007FFF", rd); end
        do_req(1'b0, 2'b01, 1'b1, 12'h022, 32'h0, lat, err, rd, wc, wa);
        total++;
        if (rd !== 32'h00008001) begin bad++; $display("FAIL half_load_unsigned: got %h want 00008001", rd); end
        do_req(1'b1, 2'b01, 1'b0, 12'h022, 32'h1234BEEF, lat, err, rd, wc, wa);
        total++;
        if (lat !== 3 || wc !== 1 || mem[8] !== 32'hBEEF7FFF) begin
            bad++; $display("FAIL half_store: lat=%0d writes=%0d mem=%h want 3/1/BEEF7FFF", lat, wc, mem[8]);
        end
    endtask

    task automatic test_errors();
        int lat, wc; logic err; logic [31:0] rd; logic [11:0] wa;
        do_req(1'b1, 2'b11, 1'b0, 12'h000, 32'hCAFEF00D, lat, err, rd, wc, wa);
        do_req(1'b0, 2'b01, 1'b1, 12'h020, 32'h0, lat, err, rd, wc, wa);
        do_req(1'b0, 2'b11, 1'b0, 12'h021, 32'h0, lat, err, rd, wc, wa);
        total++;
        if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || wc !== 0) begin
            bad++; $display("FAIL err_word_load: lat=%0d err=%b rdata=%h writes=%0d want 1/1/0/0", lat, err, rd, wc);
        end
        do_req(1'b1, 2'b01, 1'b0, 12'h023, 32'h0000FFFF, lat, err, rd, wc, wa);
        total++;
        if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || wc !== 0) begin
            bad++; $display("FAIL err_half_store: lat=%0d err=%b rdata=%h writes=%0d want 1/1/0/0", lat, err, rd, wc);
        end
        do_req(1'b1, 2'b10, 1'b0, 12'h000, 32'h12345678, lat, err, rd, wc, wa);
        total++;
        if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || wc !== 0) begin
            bad++; $display("FAIL err_size10: lat=%0d err=%b rdata=%h writes=%0d want 1/1/0/0", lat, err, rd, wc);
        end
        total++;
        if (mem[0] !== 32'hCAFEF00D || mem[8] !== 32'hBEEF7FFF) begin
            bad++; $display("FAIL err_mem_unchanged: mem0=%h mem8=%h want CAFEF00D/BEEF7FFF", mem[0], mem[8]);
        end
    endtask

    task automatic test_reset_mid();
        int wc = 0, rc = 0;
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 12'h010; req_wdata = 32'h5A; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if (mem_addr !== 12'h010 || mem_we !== 1'b0) begin
            bad++; $display("FAIL rmw_rd_phase: addr=%h we=%b want 010/0", mem_addr, mem_we);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (mem_we !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0 || mem_addr !== 12'h0) begin
            bad++; $display("FAIL mid_reset_outputs: we=%b rsp=%b ready=%b addr=%h want 0", mem_we, rsp_valid, req_ready, mem_addr);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready: got %b want 1", req_ready); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_we) wc++;
            if (rsp_valid) rc++;
        end
        total++;
        if (wc !== 0 || rc !== 0 || mem[4] !== 32'hA5223344) begin
            bad++; $display("FAIL mid_reset_abandon: writes=%0d rsps=%0d mem=%h want 0/0/A5223344", wc, rc, mem[4]);
        end
        $display("reset during RMW_RD: writes=%0d rsps=%0d mem=%h", wc, rc, mem[4]);
    endtask

    task automatic test_back_to_back();
        logic [11:0] addrs [3];
        logic [31:0] datas [3];
        int acc_cyc [3];
        int rsp_cyc [3];
        int idx = 0, accepts = 0, rsps = 0, wr = 0;
        logic pending = 1'b0;
        addrs = '{12'h030, 12'h031, 12'h032};
        datas = '{32'h11, 32'h22, 32'h33};
        acc_cyc = '{-1, -1, -1};
        rsp_cyc = '{-1, -1, -1};
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = addrs[0]; req_wdata = datas[0]; req_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid) begin
                if (rsps < 3) rsp_cyc[rsps] = c;
                rsps++;
            end
            if (mem_we) wr++;
            if (req_ready && req_valid) begin
                if (accepts < 3) acc_cyc[accepts] = c;
                accepts++;
                pending = 1'b1;
            end
            @(negedge clk);
            if (pending) begin
                pending = 1'b0;
                idx++;
                if (idx < 3) begin req_addr = addrs[idx]; req_wdata = datas[idx]; end
                else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        $display("back-to-back: accepts=%0d at %0d,%0d,%0d rsps=%0d at %0d,%0d,%0d writes=%0d mem=%h",
                 accepts, acc_cyc[0], acc_cyc[1], acc_cyc[2], rsps, rsp_cyc[0], rsp_cyc[1], rsp_cyc[2], wr, mem[12]);
        total++;
        if (accepts !== 3 || rsps !== 3 || wr !== 3) begin
            bad++; $display("FAIL b2b_counts: accepts=%0d rsps=%0d writes=%0d want 3/3/3", accepts, rsps, wr);
        end
        total++;
        if (acc_cyc[0] !== 0 || acc_cyc[1] !== 4 || acc_cyc[2] !== 8) begin
            bad++; $display("FAIL b2b_accept_cycles: got %0d,%0d,%0d want 0,4,8", acc_cyc[0], acc_cyc[1], acc_cyc[2]);
        end
        total++;
        if (rsp_cyc[0] !== 3 || rsp_cyc[1] !== 7 || rsp_cyc[2] !== 11) begin
            bad++; $display("FAIL b2b_rsp_cycles: got %0d,%0d,%0d want 3,7,11", rsp_cyc[0], rsp_cyc[1], rsp_cyc[2]);
        end
        total++;
        if (mem[12] !== 32'h00332211) begin bad++; $display("FAIL b2b_mem: got %h want 00332211", mem[12]); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        test_reset();
        test_word_store_load();
        test_byte_rmw();
        test_half();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
